// File: rtl/adxl_spi_responder_if.sv
// SPI bus between a command master and the ADXL362 register-file responder.
// Signals:
//   CS   - chip select, active low, driven by the master
//   SCLK - SPI clock, idle low (mode 0), driven by the master
//   MOSI - master-to-slave data, sampled by the slave on SCLK rise
//   MISO - slave-to-master data, changed by the slave on SCLK fall
interface adxl_spi_responder_if;
  logic CS;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output CS, output SCLK, output MOSI, input MISO);
  modport slave  (input CS, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/adxl_spi_responder.sv
// SPI mode-0 slave emulating the ADXL362 register file. It answers the
// 3-byte write (0x0A) and read (0x0B) commands, including bursts with
// 6-bit address auto-increment.
// Ports:
//   clk, reset          - system clock, synchronous active-low reset
//   spi (slave modport) - CS/SCLK/MOSI in, MISO out
//   i_x/y/z_data        - accelerometer sample values (regs 0x08..0x0A)
//   i_temp_data         - temperature sample (regs 0x14/0x15)
//   i_sample_upd        - 1-clk pulse capturing the sample inputs
//   o_meas_en           - POWER_CTL[1:0] == 2'b10
//   o_filter_ctl        - mirror of FILTER_CTL (0x2C)
//   o_wr_strobe/addr/data - one pulse per committed write byte
//   o_cmd_err           - pulse on an unknown instruction byte
module adxl_spi_responder #(
  parameter int          ADDR_W    = 6,
  parameter logic [7:0]  DEVID_AD  = 8'hAD,
  parameter logic [7:0]  DEVID_MST = 8'h1D,
  parameter int          SYNC_STG  = 2
) (
  input  logic              clk,
  input  logic              reset,
  adxl_spi_responder_if.slave spi,
  input  logic [7:0]        i_x_data,
  input  logic [7:0]        i_y_data,
  input  logic [7:0]        i_z_data,
  input  logic [11:0]       i_temp_data,
  input  logic              i_sample_upd,
  output logic              o_meas_en,
  output logic [7:0]        o_filter_ctl,
  output logic              o_wr_strobe,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_cmd_err
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] A_DEVID_AD  = ADDR_W'('h00);
  localparam logic [ADDR_W-1:0] A_DEVID_MST = ADDR_W'('h01);
  localparam logic [ADDR_W-1:0] A_XDATA     = ADDR_W'('h08);
  localparam logic [ADDR_W-1:0] A_YDATA     = ADDR_W'('h09);
  localparam logic [ADDR_W-1:0] A_ZDATA     = ADDR_W'('h0A);
  localparam logic [ADDR_W-1:0] A_TEMP_L    = ADDR_W'('h14);
  localparam logic [ADDR_W-1:0] A_TEMP_H    = ADDR_W'('h15);
  localparam logic [ADDR_W-1:0] A_SOFT_RST  = ADDR_W'('h1F);
  localparam logic [ADDR_W-1:0] A_FILTER    = ADDR_W'('h2C);
  localparam logic [ADDR_W-1:0] A_POWER     = ADDR_W'('h2D);

  typedef enum logic [2:0] {
    S_IDLE, S_INSTR, S_ADDR_W, S_ADDR_R, S_WRITE, S_READ, S_IGNORE
  } state_t;

  state_t              r_state;
  logic [SYNC_STG-1:0] r_cs_sync, r_sclk_sync, r_mosi_sync;
  logic                r_cs_d, r_sclk_d;
  logic [2:0]          r_bit_cnt;
  logic [6:0]          r_rx_shift;
  logic [7:0]          r_tx_shift;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_soft_arm;
  logic                r_pend_v;
  logic [7:0]          r_pend_x, r_pend_y, r_pend_z;
  logic [11:0]         r_pend_t;
  logic [7:0]          r_regs [NREG];

  logic       w_cs, w_sclk, w_mosi;
  logic       w_cs_rise, w_cs_fall, w_sclk_rise, w_sclk_fall;
  logic       w_byte_done, w_commit, w_arm_now;
  logic [7:0] w_byte, w_rd_val;

  function automatic logic f_read_only(input logic [ADDR_W-1:0] a);
    return (a == A_DEVID_AD) || (a == A_DEVID_MST) || (a == A_XDATA) ||
           (a == A_YDATA) || (a == A_ZDATA) || (a == A_TEMP_L) ||
           (a == A_TEMP_H) || (a == A_SOFT_RST);
  endfunction

  assign w_cs   = r_cs_sync[SYNC_STG-1];
  assign w_sclk = r_sclk_sync[SYNC_STG-1];
  assign w_mosi = r_mosi_sync[SYNC_STG-1];

  assign w_cs_rise   =  w_cs   & ~r_cs_d;
  assign w_cs_fall   = ~w_cs   &  r_cs_d;
  assign w_sclk_rise =  w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk &  r_sclk_d;

  // Byte as it will look after this rise; only meaningful on the 8th rise.
  assign w_byte      = {r_rx_shift, w_mosi};
  assign w_byte_done = (r_state != S_IDLE) && w_sclk_rise && (r_bit_cnt == 3'd7);
  assign w_commit    = w_byte_done && (r_state == S_WRITE);
  assign w_arm_now   = w_commit && (r_addr == A_SOFT_RST) && (w_byte == 8'h52);

  always_comb begin
    w_rd_val = r_regs[r_addr];
    if (r_addr == A_DEVID_AD)       w_rd_val = DEVID_AD;
    else if (r_addr == A_DEVID_MST) w_rd_val = DEVID_MST;
    else if (r_addr == A_SOFT_RST)  w_rd_val = 8'h00;
  end

  assign spi.MISO     = r_tx_shift[7];
  assign o_meas_en    = (r_regs[A_POWER][1:0] == 2'b10);
  assign o_filter_ctl = r_regs[A_FILTER];

  always_ff @(posedge clk) begin
    if (!reset) begin
      // CS resets to "low" so a transaction already in flight is ignored
      // until CS is genuinely seen high.
      r_cs_sync   <= '0;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_d      <= 1'b0;
      r_sclk_d    <= 1'b0;
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_tx_shift  <= '0;
      r_addr      <= '0;
      r_soft_arm  <= 1'b0;
      r_pend_v    <= 1'b0;
      r_pend_x    <= '0;
      r_pend_y    <= '0;
      r_pend_z    <= '0;
      r_pend_t    <= '0;
      o_wr_strobe <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_cmd_err   <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[ADDR_W'(i)] <= 8'h00;
    end else begin
      r_cs_sync   <= (r_cs_sync << 1)   | SYNC_STG'(spi.CS);
      r_sclk_sync <= (r_sclk_sync << 1) | SYNC_STG'(spi.SCLK);
      r_mosi_sync <= (r_mosi_sync << 1) | SYNC_STG'(spi.MOSI);
      r_cs_d      <= w_cs;
      r_sclk_d    <= w_sclk;
      o_wr_strobe <= 1'b0;
      o_cmd_err   <= 1'b0;

      if ((r_state != S_IDLE) && w_sclk_rise) begin
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        r_rx_shift <= w_byte[6:0];
      end

      if (w_byte_done) begin
        case (r_state)
          S_INSTR: begin
            if (w_byte == 8'h0A)      r_state <= S_ADDR_W;
            else if (w_byte == 8'h0B) r_state <= S_ADDR_R;
            else begin
              r_state   <= S_IGNORE;
              o_cmd_err <= 1'b1;
            end
          end
          S_ADDR_W: begin
            r_addr  <= w_byte[ADDR_W-1:0];
            r_state <= S_WRITE;
          end
          S_ADDR_R: begin
            r_addr  <= w_byte[ADDR_W-1:0];
            r_state <= S_READ;
          end
          S_WRITE: begin
            o_wr_strobe <= 1'b1;
            o_wr_addr   <= r_addr;
            o_wr_data   <= w_byte;
            if (!f_read_only(r_addr)) r_regs[r_addr] <= w_byte;
            r_addr <= r_addr + ADDR_W'(1);
          end
          S_READ:  r_addr <= r_addr + ADDR_W'(1);
          default: ;
        endcase
      end

      if (w_arm_now) r_soft_arm <= 1'b1;

      // bit_cnt==0 on a fall means the previous byte just completed, so the
      // (possibly incremented) address is fetched for the new byte.
      if ((r_state == S_READ) && w_sclk_fall) begin
        if (r_bit_cnt == 3'd0) r_tx_shift <= w_rd_val;
        else                   r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end

      // Placed after the byte logic so a simultaneous 8th rise commits first.
      if (w_cs_rise) begin
        r_state    <= S_IDLE;
        r_bit_cnt  <= '0;
        r_tx_shift <= '0;
        r_soft_arm <= 1'b0;
        if (r_soft_arm || w_arm_now) begin
          for (int i = 0; i < NREG; i++)
            if (!f_read_only(ADDR_W'(i))) r_regs[ADDR_W'(i)] <= 8'h00;
        end
        if (r_pend_v) begin
          r_regs[A_XDATA]  <= r_pend_x;
          r_regs[A_YDATA]  <= r_pend_y;
          r_regs[A_ZDATA]  <= r_pend_z;
          r_regs[A_TEMP_L] <= r_pend_t[7:0];
          r_regs[A_TEMP_H] <= {4'b0000, r_pend_t[11:8]};
          r_pend_v         <= 1'b0;
        end
      end else if ((r_state == S_IDLE) && w_cs_fall) begin
        r_state <= S_INSTR;
      end

      // Samples never land mid-burst: while CS is low they wait for CS rise.
      if (i_sample_upd) begin
        if (w_cs) begin
          r_regs[A_XDATA]  <= i_x_data;
          r_regs[A_YDATA]  <= i_y_data;
          r_regs[A_ZDATA]  <= i_z_data;
          r_regs[A_TEMP_L] <= i_temp_data[7:0];
          r_regs[A_TEMP_H] <= {4'b0000, i_temp_data[11:8]};
        end else begin
          r_pend_v <= 1'b1;
          r_pend_x <= i_x_data;
          r_pend_y <= i_y_data;
          r_pend_z <= i_z_data;
          r_pend_t <= i_temp_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_adxl_spi_responder.sv
// Bench for adxl_spi_responder: drives SPI frames as a mode-0 master and
// checks MISO bytes, write strobes, cmd_err and the mirrored outputs against
// a register-level model of the ADXL362 register map.
module tb_adxl_spi_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  x_d, y_d, z_d;
  logic [11:0] t_d;
  logic        upd;
  logic        o_meas_en, o_wr_strobe, o_cmd_err;
  logic [7:0]  o_filter_ctl, o_wr_data;
  logic [5:0]  o_wr_addr;

  always #5 clk = ~clk;

  adxl_spi_responder_if spi_bus();

  adxl_spi_responder dut (
    .clk          (clk),
    .reset        (reset),
    .spi          (spi_bus),
    .i_x_data     (x_d),
    .i_y_data     (y_d),
    .i_z_data     (z_d),
    .i_temp_data  (t_d),
    .i_sample_upd (upd),
    .o_meas_en    (o_meas_en),
    .o_filter_ctl (o_filter_ctl),
    .o_wr_strobe  (o_wr_strobe),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_cmd_err    (o_cmd_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- register-map model ----------------
  logic [7:0]  m_regs [64];
  bit          m_pend_v;
  logic [7:0]  m_px, m_py, m_pz;
  logic [11:0] m_pt;
  logic [13:0] m_strb_q [$];
  int          err_seen, strobe_cnt;
  bit          idle_chk;

  function automatic bit m_ro(input int a);
    return (a == 0) || (a == 1) || (a == 8) || (a == 9) || (a == 10) ||
           (a == 20) || (a == 21) || (a == 31);
  endfunction

  function automatic logic [7:0] m_rd(input int a);
    if (a == 0)  return 8'hAD;
    if (a == 1)  return 8'h1D;
    if (a == 31) return 8'h00;
    return m_regs[a];
  endfunction

  function automatic void m_apply(input logic [7:0] x, input logic [7:0] y,
                                  input logic [7:0] z, input logic [11:0] t);
    m_regs[8]  = x;
    m_regs[9]  = y;
    m_regs[10] = z;
    m_regs[20] = t[7:0];
    m_regs[21] = {4'b0000, t[11:8]};
  endfunction

  // ---------------- compare process ----------------
  logic [13:0] exp_strb;
  always @(negedge clk) begin
    if (o_wr_strobe) begin
      strobe_cnt++;
      if (m_strb_q.size() == 0) chk("strobe_unexpected", o_wr_strobe, 0);
      else begin
        exp_strb = m_strb_q.pop_front();
        chk("wr_addr", o_wr_addr, exp_strb[13:8]);
        chk("wr_data", o_wr_data, exp_strb[7:0]);
      end
    end
    if (o_cmd_err) err_seen++;
    if (idle_chk) begin
      chk("miso_idle", spi_bus.MISO, 0);
      chk("meas_en", o_meas_en, m_regs[45][1:0] == 2'b10);
      chk("filter_ctl", o_filter_ctl, m_regs[44]);
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];
  int frame_no = 0;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sample(input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] z, input logic [11:0] t);
    x_d = x; y_d = y; z_d = z; t_d = t;
  endtask

  task automatic pulse_sample();
    upd = 1'b1;
    wait_clk(1);
    upd = 1'b0;
    if (spi_bus.CS) m_apply(x_d, y_d, z_d, t_d);
    else begin
      m_pend_v = 1'b1;
      m_px = x_d; m_py = y_d; m_pz = z_d; m_pt = t_d;
    end
  endtask

  task automatic spi_frame(input int nbits, input int upd_byte);
    logic [7:0] sh;
    sh = 8'h00;
    rx_q.delete();
    spi_bus.CS = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      if ((i % 8 == 0) && (i / 8 == upd_byte)) pulse_sample();
      spi_bus.MOSI = tx_q[i / 8][7 - (i % 8)];
      wait_clk(8);
      spi_bus.SCLK = 1'b1;
      sh = {sh[6:0], spi_bus.MISO};
      if (i % 8 == 7) rx_q.push_back(sh);
      wait_clk(8);
      spi_bus.SCLK = 1'b0;
    end
    wait_clk(8);
    spi_bus.CS   = 1'b1;
    spi_bus.MOSI = 1'b0;
    wait_clk(12);
  endtask

  // Predicts a whole frame from the register map, runs it, then checks it.
  task automatic run(input int nbits, input int upd_byte);
    int nb, a, err_exp;
    bit arm;
    logic [7:0] instr, d;
    logic [7:0] exp_rx [$];
    idle_chk = 1'b0;
    nb = nbits / 8; a = 0; arm = 1'b0; err_exp = 0;
    instr = tx_q[0];
    for (int i = 0; i < nb; i++) begin
      d = tx_q[i];
      if (i == 1) a = int'(d[5:0]);
      if (i < 2) exp_rx.push_back(8'h00);
      else if (instr == 8'h0B) begin
        exp_rx.push_back(m_rd(a));
        a = (a + 1) % 64;
      end else begin
        exp_rx.push_back(8'h00);
        if (instr == 8'h0A) begin
          m_strb_q.push_back({a[5:0], d});
          if (!m_ro(a)) m_regs[a] = d;
          if (a == 31 && d == 8'h52) arm = 1'b1;
          a = (a + 1) % 64;
        end
      end
    end
    if (nb >= 1 && instr != 8'h0A && instr != 8'h0B) err_exp = 1;
    err_seen = 0;
    strobe_cnt = 0;
    frame_no++;
    $display("frame %0d: instr 0x%02h, %0d bits, %0d data bytes", frame_no, instr, nbits, nb);
    spi_frame(nbits, upd_byte);
    for (int i = 0; i < nb; i++) chk($sformatf("miso_byte%0d", i), rx_q[i], exp_rx[i]);
    chk("cmd_err_pulses", err_seen, err_exp);
    chk("strobes_pending", m_strb_q.size(), 0);
    m_strb_q.delete();
    if (arm) for (int r = 0; r < 64; r++) if (!m_ro(r)) m_regs[r] = 8'h00;
    if (m_pend_v) begin
      m_apply(m_px, m_py, m_pz, m_pt);
      m_pend_v = 1'b0;
    end
    idle_chk = 1'b1;
    wait_clk(4);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; upd = 1'b0; idle_chk = 1'b0; m_pend_v = 1'b0;
    spi_bus.CS = 1'b1; spi_bus.SCLK = 1'b0; spi_bus.MOSI = 1'b0;
    set_sample(8'h00, 8'h00, 8'h00, 12'h000);
    for (int r = 0; r < 64; r++) m_regs[r] = 8'h00;
    wait_clk(5);
    reset = 1'b1;
    wait_clk(6);
    chk("rst_miso", spi_bus.MISO, 0);
    chk("rst_meas_en", o_meas_en, 0);
    chk("rst_filter", o_filter_ctl, 8'h00);
    chk("rst_strobe", o_wr_strobe, 0);
    chk("rst_wr_addr", o_wr_addr, 6'h00);
    chk("rst_wr_data", o_wr_data, 8'h00);
    chk("rst_cmd_err", o_cmd_err, 0);
    idle_chk = 1'b1;
    wait_clk(4);

    tx_q = {8'h0B, 8'h00, 8'h00};               run(24, -1);
    chk("rd_devid_ad", rx_q[2], 8'hAD);
    tx_q = {8'h0B, 8'h00, 8'h00, 8'h00};        run(32, -1);
    chk("burst_ad", rx_q[2], 8'hAD);
    chk("burst_mst", rx_q[3], 8'h1D);

    tx_q = {8'h0A, 8'h2D, 8'h02};               run(24, -1);
    chk("meas_en_set", o_meas_en, 1);
    chk("power_strobes", strobe_cnt, 1);
    tx_q = {8'h0B, 8'h2D, 8'h00};               run(24, -1);
    chk("rd_power", rx_q[2], 8'h02);
    tx_q = {8'h0A, 8'h2C, 8'h14};               run(24, -1);
    chk("filter_set", o_filter_ctl, 8'h14);

    tx_q = {8'h0A, 8'h1F, 8'h52};               run(24, -1);
    chk("soft_rst_filter", o_filter_ctl, 8'h00);
    chk("soft_rst_meas", o_meas_en, 0);
    tx_q = {8'h0B, 8'h00, 8'h00};               run(24, -1);
    chk("soft_rst_devid", rx_q[2], 8'hAD);

    set_sample(8'h11, 8'h22, 8'h33, 12'hABC);
    pulse_sample();
    wait_clk(3);
    tx_q = {8'h0B, 8'h08, 8'h00, 8'h00, 8'h00}; run(40, -1);
    chk("rd_x", rx_q[2], 8'h11);
    chk("rd_y", rx_q[3], 8'h22);
    chk("rd_z", rx_q[4], 8'h33);
    tx_q = {8'h0B, 8'h14, 8'h00};               run(24, -1);
    chk("rd_temp_l", rx_q[2], 8'hBC);
    tx_q = {8'h0B, 8'h15, 8'h00};               run(24, -1);
    chk("rd_temp_h", rx_q[2], 8'h0A);

    set_sample(8'h44, 8'h55, 8'h66, 12'h123);
    tx_q = {8'h0B, 8'h08, 8'h00, 8'h00, 8'h00}; run(40, 2);
    chk("held_x", rx_q[2], 8'h11);
    chk("held_z", rx_q[4], 8'h33);
    tx_q = {8'h0B, 8'h08, 8'h00};               run(24, -1);
    chk("new_x", rx_q[2], 8'h44);

    tx_q = {8'h0D, 8'h00, 8'h00};               run(24, -1);
    chk("bad_cmd_err", err_seen, 1);
    chk("bad_cmd_miso", rx_q[2], 8'h00);

    tx_q = {8'h0A, 8'h3F, 8'h55, 8'h66};        run(32, -1);
    chk("wrap_strobes", strobe_cnt, 2);
    tx_q = {8'h0B, 8'h3F, 8'h00, 8'h00};        run(32, -1);
    chk("rd_3f", rx_q[2], 8'h55);
    chk("rd_wrap_00", rx_q[3], 8'hAD);

    tx_q = {8'h0A, 8'h2E, 8'hF7};               run(20, -1);
    chk("partial_strobes", strobe_cnt, 0);
    tx_q = {8'h0B, 8'h2E, 8'h00};               run(24, -1);
    chk("partial_rd", rx_q[2], 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
